ifu_fetch: RTL and testbench

Instruction fetch unit for the multi-cycle core: holds the architectural PC, fetches one 32-bit instruction per cycle of operation from instruction memory over a request/response port, and presents `{inst, pc}` to the decode stage over the valid/ready handshake that decode consumes (`ifu_valid` / `ifu_data` / `idu_ready`). After decode accepts an instruction, the unit waits for the next PC from write-back before fetching again. This is the transmitter end of the fetch→decode interface.

---
 rtl/ifu_fetch_if.sv | 27 ++
 rtl/ifu_fetch.sv | 119 +++++++++++
 tb/tb_ifu_fetch.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ifu_fetch_if.sv
// Fetch-unit port bundle: instruction-memory request/response, decode handoff, next-PC input.
// master = fetch unit side, slave = memory/decode/write-back side.
// Purely structural; no storage.
interface ifu_fetch_if;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        ifu_valid;
   logic [63:0] ifu_data;
   logic        idu_ready;
   logic        npc_valid;
   logic [31:0] npc;
   logic        ifu_misalign;
   logic [31:0] fetch_cnt;

   modport master (
      output imem_req_valid, imem_addr, ifu_valid, ifu_data, ifu_misalign, fetch_cnt,
      input  imem_req_ready, imem_rsp_valid, imem_rsp_data, idu_ready, npc_valid, npc
   );

   modport slave (
      input  imem_req_valid, imem_addr, ifu_valid, ifu_data, ifu_misalign, fetch_cnt,
      output imem_req_ready, imem_rsp_valid, imem_rsp_data, idu_ready, npc_valid, npc
   );
endinterface

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: holds PC, fetches one word, hands {inst, pc} to decode, waits for next PC.
// Latency: REQ -> WAIT_RSP -> SEND -> WAIT_NPC -> REQ, minimum 4 cycles per instruction.
// Backpressure: request held stable until imem_req_ready; ifu_data held until idu_ready.
// Optional macro IFU_MISALIGN_CHECK_EN: misaligned PC skips memory and presents an ebreak trap.
module ifu_fetch #(
   parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
   input logic         clk,
   input logic         rst,
   ifu_fetch_if.master bus
);

   typedef enum logic [1:0] {S_REQ, S_WAIT_RSP, S_SEND, S_WAIT_NPC} state_t;

   typedef struct packed {
      logic [31:0] inst;
      logic [31:0] pc;
   } fetch_pkt_t;

   localparam logic [31:0] EBREAK = 32'h0010_0073;

   state_t      state_q, state_d;
   logic [31:0] pc_q;
   logic [31:0] inst_q;
   logic [31:0] fetch_cnt_q;
   logic        req_valid;
   logic        rsp_take;
   logic        send_fire;
   logic        npc_take;
   logic        misalign_trap;
   fetch_pkt_t  pkt;

`ifdef IFU_MISALIGN_CHECK_EN
   logic        misalign_q;
   assign misalign_trap = (state_q == S_REQ) && (pc_q[1:0] != 2'b00);
`else
   assign misalign_trap = 1'b0;
`endif

   // Next-state and handshake decode; each input is only honoured in its own state.
   always_comb begin
      state_d   = state_q;
      req_valid = 1'b0;
      rsp_take  = 1'b0;
      send_fire = 1'b0;
      npc_take  = 1'b0;
      case (state_q)
         S_REQ: begin
            if (misalign_trap) begin
               state_d = S_SEND;
            end else begin
               req_valid = 1'b1;
               if (bus.imem_req_ready) state_d = S_WAIT_RSP;
            end
         end
         S_WAIT_RSP: begin
            if (bus.imem_rsp_valid) begin
               rsp_take = 1'b1;
               state_d  = S_SEND;
            end
         end
         S_SEND: begin
            if (bus.idu_ready) begin
               send_fire = 1'b1;
               state_d   = S_WAIT_NPC;
            end
         end
         S_WAIT_NPC: begin
            if (bus.npc_valid) begin
               npc_take = 1'b1;
               state_d  = S_REQ;
            end
         end
         default: state_d = S_REQ;
      endcase
   end

   // State register; reset abandons any outstanding request.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_REQ;
      else     state_q <= state_d;
   end

   // PC, instruction and delivered-instruction counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q        <= RESET_PC;
         inst_q      <= 32'd0;
         fetch_cnt_q <= 32'd0;
      end else begin
         if (npc_take)           pc_q        <= bus.npc;
         if (rsp_take)           inst_q      <= bus.imem_rsp_data;
         else if (misalign_trap) inst_q      <= EBREAK;
         if (send_fire)          fetch_cnt_q <= fetch_cnt_q + 32'd1;
      end
   end

`ifdef IFU_MISALIGN_CHECK_EN
   // Trap flag travels with the instruction it describes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                misalign_q <= 1'b0;
      else if (rsp_take)      misalign_q <= 1'b0;
      else if (misalign_trap) misalign_q <= 1'b1;
   end
   assign bus.ifu_misalign = misalign_q && (state_q == S_SEND);
`else
   assign bus.ifu_misalign = 1'b0;
`endif

   assign pkt.inst = inst_q;
   assign pkt.pc   = pc_q;

   assign bus.imem_req_valid = req_valid;
   assign bus.imem_addr      = pc_q;
   assign bus.ifu_valid      = (state_q == S_SEND);
   assign bus.ifu_data       = pkt;
   assign bus.fetch_cnt      = fetch_cnt_q;

endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: directed scenarios, scoreboard of expected {inst, pc} per decode handoff.
// Inputs driven 1 time unit after the rising edge; outputs sampled there too.
// Misalign scenario follows IFU_MISALIGN_CHECK_EN in the same way as the design.
module tb_ifu_fetch;

   localparam logic [31:0] RESET_PC = 32'h8000_0000;

   logic clk = 1'b0;
   logic rst;

   ifu_fetch_if bus();

   ifu_fetch #(.RESET_PC(RESET_PC)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int          errors = 0;
   int          checks = 0;
   logic [31:0] exp_cnt;
   logic [63:0] exp_q[$];

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs;
      bus.imem_req_ready = 1'b0;
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = 32'd0;
      bus.idu_ready      = 1'b0;
      bus.npc_valid      = 1'b0;
      bus.npc            = 32'd0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      idle_inputs();
      exp_cnt = 32'd0;
      repeat (2) tick();
      checks++; if (bus.imem_req_valid !== 1'b1) begin errors++; $display("FAIL rst_req_valid: got %b want 1", bus.imem_req_valid); end
      checks++; if (bus.imem_addr !== RESET_PC) begin errors++; $display("FAIL rst_addr: got %h want %h", bus.imem_addr, RESET_PC); end
      checks++; if (bus.ifu_valid !== 1'b0) begin errors++; $display("FAIL rst_ifu_valid: got %b want 0", bus.ifu_valid); end
      checks++; if (bus.fetch_cnt !== 32'd0) begin errors++; $display("FAIL rst_fetch_cnt: got %h want 0", bus.fetch_cnt); end
      checks++; if (bus.ifu_misalign !== 1'b0) begin errors++; $display("FAIL rst_misalign: got %b want 0", bus.ifu_misalign); end
      rst = 1'b0;
      tick();
      checks++; if (bus.imem_req_valid !== 1'b1 || bus.imem_addr !== RESET_PC) begin errors++; $display("FAIL post_rst_req: got %b/%h want 1/%h", bus.imem_req_valid, bus.imem_addr, RESET_PC); end
   endtask

   task automatic test_basic;
      logic [63:0] e;
      // cycle 0: REQ
      bus.imem_req_ready = 1'b1;
      bus.idu_ready      = 1'b1;
      bus.npc_valid      = 1'b1;
      bus.npc            = 32'h8000_0004;
      checks++; if (bus.imem_req_valid !== 1'b1 || bus.imem_addr !== 32'h8000_0000) begin errors++; $display("FAIL basic_req: got %b/%h want 1/80000000", bus.imem_req_valid, bus.imem_addr); end
      tick();
      // cycle 1: WAIT_RSP
      checks++; if (bus.imem_req_valid !== 1'b0 || bus.ifu_valid !== 1'b0) begin errors++; $display("FAIL basic_wait: got req=%b ifu=%b want 0/0", bus.imem_req_valid, bus.ifu_valid); end
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = 32'h0050_0093;
      exp_q.push_back({32'h0050_0093, 32'h8000_0000});
      tick();
      // cycle 2: SEND
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = 32'd0;
      checks++; if (bus.ifu_valid !== 1'b1) begin errors++; $display("FAIL basic_ifu_valid: got %b want 1", bus.ifu_valid); end
      e = exp_q.pop_front();
      checks++; if (bus.ifu_data !== e) begin errors++; $display("FAIL basic_sb_data: got %h want %h", bus.ifu_data, e); end
      exp_cnt++;
      tick();
      // cycle 3: WAIT_NPC
      checks++; if (bus.ifu_valid !== 1'b0 || bus.imem_req_valid !== 1'b0) begin errors++; $display("FAIL basic_wait_npc: got ifu=%b req=%b want 0/0", bus.ifu_valid, bus.imem_req_valid); end
      checks++; if (bus.fetch_cnt !== exp_cnt) begin errors++; $display("FAIL basic_fetch_cnt: got %h want %h", bus.fetch_cnt, exp_cnt); end
      tick();
      // cycle 4: REQ at new PC
      checks++; if (bus.imem_req_valid !== 1'b1 || bus.imem_addr !== 32'h8000_0004) begin errors++; $display("FAIL basic_next_req: got %b/%h want 1/80000004", bus.imem_req_valid, bus.imem_addr); end
      idle_inputs();
   endtask

   task automatic test_req_stall;
      logic [63:0] e;
      int accepts;
      accepts = 0;
      for (int i = 0; i < 3; i++) begin
         checks++; if (bus.imem_req_valid !== 1'b1 || bus.imem_addr !== 32'h8000_0004) begin errors++; $display("FAIL stall_hold_%0d: got %b/%h want 1/80000004", i, bus.imem_req_valid, bus.imem_addr); end
         tick();
      end
      bus.imem_req_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (bus.imem_req_valid === 1'b1) accepts++;
         tick();
      end
      checks++; if (accepts != 1) begin errors++; $display("FAIL stall_accepts: got %0d want 1", accepts); end
      bus.imem_req_ready = 1'b0;
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = 32'h00A0_0113;
      exp_q.push_back({32'h00A0_0113, 32'h8000_0004});
      tick();
      bus.imem_rsp_valid = 1'b0;
      checks++; if (bus.ifu_valid !== 1'b1) begin errors++; $display("FAIL stall_ifu_valid: got %b want 1", bus.ifu_valid); end
      bus.idu_ready = 1'b1;
      bus.npc       = 32'h8000_0008;
      bus.npc_valid = 1'b1;
      e = exp_q.pop_front();
      checks++; if (bus.ifu_data !== e) begin errors++; $display("FAIL stall_sb_data: got %h want %h", bus.ifu_data, e); end
      exp_cnt++;
      tick();
      bus.idu_ready = 1'b0;
      tick();
      idle_inputs();
      checks++; if (bus.imem_req_valid !== 1'b1 || bus.imem_addr !== 32'h8000_0008) begin errors++; $display("FAIL stall_next_req: got %b/%h want 1/80000008", bus.imem_req_valid, bus.imem_addr); end
      checks++; if (bus.fetch_cnt !== exp_cnt) begin errors++; $display("FAIL stall_fetch_cnt: got %h want %h", bus.fetch_cnt, exp_cnt); end
   endtask

   task automatic test_stall_send;
      logic [63:0] e;
      bus.imem_req_ready = 1'b1;
      tick();
      bus.imem_req_ready = 1'b0;
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = 32'h0020_81B3;
      exp_q.push_back({32'h0020_81B3, 32'h8000_0008});
      tick();
      bus.imem_rsp_valid = 1'b0;
      bus.npc            = 32'h1234_5678;
      for (int i = 0; i < 5; i++) begin
         bus.npc_valid = (i == 2);
         checks++; if (bus.ifu_valid !== 1'b1) begin errors++; $display("FAIL send_hold_valid_%0d: got %b want 1", i, bus.ifu_valid); end
         checks++; if (bus.ifu_data !== {32'h0020_81B3, 32'h8000_0008}) begin errors++; $display("FAIL send_hold_data_%0d: got %h want 002081b380000008", i, bus.ifu_data); end
         checks++; if (bus.fetch_cnt !== exp_cnt) begin errors++; $display("FAIL send_hold_cnt_%0d: got %h want %h", i, bus.fetch_cnt, exp_cnt); end
         tick();
      end
      bus.npc_valid = 1'b0;
      bus.idu_ready = 1'b1;
      e = exp_q.pop_front();
      checks++; if (bus.ifu_data !== e) begin errors++; $display("FAIL send_sb_data: got %h want %h", bus.ifu_data, e); end
      exp_cnt++;
      tick();
      bus.idu_ready = 1'b0;
      checks++; if (bus.fetch_cnt !== exp_cnt) begin errors++; $display("FAIL send_fetch_cnt: got %h want %h", bus.fetch_cnt, exp_cnt); end
      for (int i = 0; i < 3; i++) begin
         checks++; if (bus.imem_req_valid !== 1'b0 || bus.ifu_valid !== 1'b0) begin errors++; $display("FAIL npc_wait_%0d: got req=%b ifu=%b want 0/0", i, bus.imem_req_valid, bus.ifu_valid); end
         tick();
      end
      bus.npc       = 32'h8000_000C;
      bus.npc_valid = 1'b1;
      tick();
      bus.npc_valid = 1'b0;
      checks++; if (bus.imem_req_valid !== 1'b1 || bus.imem_addr !== 32'h8000_000C) begin errors++; $display("FAIL npc_next_req: got %b/%h want 1/8000000c", bus.imem_req_valid, bus.imem_addr); end
   endtask

   task automatic test_reset_mid;
      logic [63:0] e;
      bus.imem_req_ready = 1'b1;
      tick();
      bus.imem_req_ready = 1'b0;
      checks++; if (bus.imem_req_valid !== 1'b0) begin errors++; $display("FAIL rmid_wait_rsp: got %b want 0", bus.imem_req_valid); end
      rst = 1'b1;
      #1;
      exp_cnt = 32'd0;
      checks++; if (bus.imem_req_valid !== 1'b1 || bus.imem_addr !== RESET_PC) begin errors++; $display("FAIL rmid_async: got %b/%h want 1/%h", bus.imem_req_valid, bus.imem_addr, RESET_PC); end
      checks++; if (bus.fetch_cnt !== exp_cnt) begin errors++; $display("FAIL rmid_cnt: got %h want %h", bus.fetch_cnt, exp_cnt); end
      tick();
      rst = 1'b0;
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = 32'hDEAD_BEEF;
      for (int i = 0; i < 2; i++) begin
         checks++; if (bus.ifu_valid !== 1'b0 || bus.imem_req_valid !== 1'b1 || bus.imem_addr !== RESET_PC) begin errors++; $display("FAIL rmid_late_rsp_%0d: got ifu=%b req=%b addr=%h want 0/1/%h", i, bus.ifu_valid, bus.imem_req_valid, bus.imem_addr, RESET_PC); end
         tick();
      end
      bus.imem_rsp_valid = 1'b0;
      bus.imem_req_ready = 1'b1;
      tick();
      bus.imem_req_ready = 1'b0;
      checks++; if (bus.ifu_valid !== 1'b0) begin errors++; $display("FAIL rmid_fresh_wait: got %b want 0", bus.ifu_valid); end
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = 32'h0000_0013;
      exp_q.push_back({32'h0000_0013, RESET_PC});
      tick();
      bus.imem_rsp_valid = 1'b0;
      bus.idu_ready      = 1'b1;
      bus.npc            = 32'h8000_0002;
      bus.npc_valid      = 1'b1;
      e = exp_q.pop_front();
      checks++; if (bus.ifu_valid !== 1'b1 || bus.ifu_data !== e) begin errors++; $display("FAIL rmid_sb_data: got %b/%h want 1/%h", bus.ifu_valid, bus.ifu_data, e); end
      exp_cnt++;
      tick();
      bus.idu_ready = 1'b0;
      tick();
      bus.npc_valid = 1'b0;
      checks++; if (bus.fetch_cnt !== exp_cnt) begin errors++; $display("FAIL rmid_fetch_cnt: got %h want %h", bus.fetch_cnt, exp_cnt); end
   endtask

   task automatic test_misalign;
      logic [63:0] e;
      checks++; if (bus.ifu_misalign !== 1'b0) begin errors++; $display("FAIL mis_req_flag: got %b want 0", bus.ifu_misalign); end
`ifdef IFU_MISALIGN_CHECK_EN
      bus.imem_req_ready = 1'b1;
      checks++; if (bus.imem_req_valid !== 1'b0) begin errors++; $display("FAIL mis_no_req: got %b want 0", bus.imem_req_valid); end
      exp_q.push_back({32'h0010_0073, 32'h8000_0002});
      tick();
      bus.imem_req_ready = 1'b0;
      checks++; if (bus.ifu_valid !== 1'b1 || bus.ifu_misalign !== 1'b1) begin errors++; $display("FAIL mis_send: got valid=%b mis=%b want 1/1", bus.ifu_valid, bus.ifu_misalign); end
`else
      checks++; if (bus.imem_req_valid !== 1'b1 || bus.imem_addr !== 32'h8000_0002) begin errors++; $display("FAIL mis_req: got %b/%h want 1/80000002", bus.imem_req_valid, bus.imem_addr); end
      bus.imem_req_ready = 1'b1;
      tick();
      bus.imem_req_ready = 1'b0;
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = 32'h0000_0013;
      exp_q.push_back({32'h0000_0013, 32'h8000_0002});
      tick();
      bus.imem_rsp_valid = 1'b0;
      checks++; if (bus.ifu_valid !== 1'b1 || bus.ifu_misalign !== 1'b0) begin errors++; $display("FAIL mis_send: got valid=%b mis=%b want 1/0", bus.ifu_valid, bus.ifu_misalign); end
`endif
      bus.idu_ready = 1'b1;
      e = exp_q.pop_front();
      checks++; if (bus.ifu_data !== e) begin errors++; $display("FAIL mis_sb_data: got %h want %h", bus.ifu_data, e); end
      exp_cnt++;
      tick();
      bus.idu_ready = 1'b0;
      checks++; if (bus.ifu_valid !== 1'b0 || bus.ifu_misalign !== 1'b0) begin errors++; $display("FAIL mis_after: got valid=%b mis=%b want 0/0", bus.ifu_valid, bus.ifu_misalign); end
      checks++; if (bus.fetch_cnt !== exp_cnt) begin errors++; $display("FAIL mis_fetch_cnt: got %h want %h", bus.fetch_cnt, exp_cnt); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_req_stall();
      test_stall_send();
      test_reset_mid();
      test_misalign();
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL sb_leftover: got %0d want 0", exp_q.size()); end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
